// File: rtl/vram_arbiter.sv
// vram_arbiter: shares the single-port VRAM bank between the VDP (absolute
// priority, never stalled) and a host port that uses the VDP's idle cycles.
// Host transaction: IDLE (latch) -> PEND (drive when VDP idle) -> DATA (ack).
// Optional macro VRAM_ARB_STARVE_EN enables the starvation counter and the
// sticky host_starve flag; when undefined host_starve is tied low.
module vram_arbiter #(
  parameter int unsigned ADDR_W       = 16,
  parameter int unsigned STARVE_LIMIT = 1024
) (
  input  logic              clk21m,
  input  logic              reset,
  input  logic              vdp_active,
  input  logic [ADDR_W-1:0] vdp_addr,
  input  logic              vdp_we,
  input  logic [7:0]        vdp_do,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [7:0]        host_din,
  output logic              host_ack,
  output logic [7:0]        host_dout,
  output logic              host_starve,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [7:0]        ram_data,
  input  logic [7:0]        ram_q
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [7:0]        r_din;
  logic [7:0]        r_dout;
  logic              w_host_drive;

  // A zero limit would make the starvation flag meaningless
  if (STARVE_LIMIT == 0) begin : g_bad_limit
    $error("vram_arbiter: STARVE_LIMIT must be nonzero");
  end

  // State register
  always_ff @(posedge clk21m) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:    if (host_req) w_next = PEND;
      PEND:    if (!vdp_active) w_next = DATA;
      DATA:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  // Host request latches and read-data holding register
  always_ff @(posedge clk21m) begin
    if (reset) begin
      r_addr <= '0;
      r_we   <= 1'b0;
      r_din  <= '0;
      r_dout <= '0;
    end else begin
      if (r_state == IDLE && host_req) begin
        r_addr <= host_addr;
        r_we   <= host_we;
        r_din  <= host_din;
      end
      if (r_state == DATA && !r_we) r_dout <= ram_q;
    end
  end

  // Host drives the bank only in PEND with the VDP idle; reset suppresses it
  assign w_host_drive = (r_state == PEND) && !vdp_active && !reset;

  // Outputs and RAM mux; read data is forwarded from ram_q in the ack cycle
  always_comb begin
    host_ack  = 1'b0;
    busy      = 1'b0;
    host_dout = r_dout;
    ram_addr  = vdp_addr;
    ram_we    = 1'b0;
    ram_data  = vdp_do;
    if (r_state != IDLE) busy = 1'b1;
    if (r_state == DATA) begin
      host_ack = 1'b1;
      if (!r_we) host_dout = ram_q;
    end
    if (vdp_active) begin
      ram_we = vdp_we;
    end else if (w_host_drive) begin
      ram_addr = r_addr;
      ram_we   = r_we;
      ram_data = r_din;
    end
  end

`ifdef VRAM_ARB_STARVE_EN
  localparam int unsigned    CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] r_cnt;
  logic             r_starve;

  // Stalled-PEND counter, saturating; flag is sticky until reset
  always_ff @(posedge clk21m) begin
    if (reset) begin
      r_cnt    <= '0;
      r_starve <= 1'b0;
    end else if (r_state == IDLE && host_req) begin
      r_cnt <= '0;
    end else if (r_state == PEND && vdp_active && r_cnt != LIMIT) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (r_cnt + CNT_W'(1) == LIMIT) r_starve <= 1'b1;
    end
  end

  assign host_starve = r_starve;
`else
  assign host_starve = 1'b0;
`endif

endmodule

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: table of host transactions with
// optional VDP contention, plus back-to-back, starvation and reset sequences.
module tb_vram_arbiter;

  localparam int unsigned ADDR_W = 16;
  localparam int unsigned LIMIT  = 8;
`ifdef VRAM_ARB_STARVE_EN
  localparam bit STARVE_ON = 1'b1;
`else
  localparam bit STARVE_ON = 1'b0;
`endif

  logic              clk21m = 1'b0;
  logic              reset;
  logic              vdp_active;
  logic [ADDR_W-1:0] vdp_addr;
  logic              vdp_we;
  logic [7:0]        vdp_do;
  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_din;
  logic              host_ack;
  logic [7:0]        host_dout;
  logic              host_starve;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [7:0]        ram_data;
  logic [7:0]        ram_q;

  logic [7:0] mem [0:65535];

  int n_chk  = 0;
  int n_fail = 0;

  vram_arbiter #(.ADDR_W(ADDR_W), .STARVE_LIMIT(LIMIT)) dut (
    .clk21m(clk21m), .reset(reset),
    .vdp_active(vdp_active), .vdp_addr(vdp_addr), .vdp_we(vdp_we), .vdp_do(vdp_do),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_din(host_din),
    .host_ack(host_ack), .host_dout(host_dout), .host_starve(host_starve), .busy(busy),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_data(ram_data), .ram_q(ram_q)
  );

  always #5 clk21m = ~clk21m;

  // VRAM model: single port, registered read-first
  always @(posedge clk21m) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        din;
    int                stall;
    logic              v_we;
    logic [ADDR_W-1:0] v_addr;
    logic [7:0]        v_do;
    logic [7:0]        exp_dout;
  } vec_t;

  // One host transaction; req dropped in T1, VDP active for 'stall' cycles
  task automatic run_txn(input vec_t v, input logic exp_starve);
    @(negedge clk21m);
    host_req = 1'b1; host_we = v.we; host_addr = v.addr; host_din = v.din;
    vdp_active = 1'b0;
    @(negedge clk21m);
    host_req = 1'b0; host_we = ~v.we; host_addr = ~v.addr; host_din = ~v.din;
    for (int i = 0; i < v.stall; i++) begin
      vdp_active = 1'b1; vdp_we = v.v_we; vdp_addr = v.v_addr; vdp_do = v.v_do;
      #1;
      chk("stall_ram_addr", 32'(ram_addr), 32'(v.v_addr));
      chk("stall_ram_we", 32'(ram_we), 32'(v.v_we));
      chk("stall_ack", 32'(host_ack), 32'd0);
      chk("stall_busy", 32'(busy), 32'd1);
      @(negedge clk21m);
    end
    vdp_active = 1'b0; vdp_we = 1'b0; vdp_addr = 16'h5555; vdp_do = 8'h00;
    #1;
    chk("acc_ram_addr", 32'(ram_addr), 32'(v.addr));
    chk("acc_ram_we", 32'(ram_we), 32'(v.we));
    if (v.we) chk("acc_ram_data", 32'(ram_data), 32'(v.din));
    chk("acc_busy", 32'(busy), 32'd1);
    chk("acc_ack", 32'(host_ack), 32'd0);
    @(negedge clk21m);
    chk("ack", 32'(host_ack), 32'd1);
    chk("ack_busy", 32'(busy), 32'd1);
    chk("ack_ram_we", 32'(ram_we), 32'd0);
    chk("ack_dout", 32'(host_dout), 32'(v.exp_dout));
    @(negedge clk21m);
    chk("post_ack", 32'(host_ack), 32'd0);
    chk("post_busy", 32'(busy), 32'd0);
    chk("post_dout_hold", 32'(host_dout), 32'(v.exp_dout));
    chk("post_starve", 32'(host_starve), 32'(exp_starve));
  endtask

  vec_t vecs [8];

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h1234] = 8'h5A;
    mem[16'hFFFF] = 8'hEE;

    //            we    addr      din    st v_we  v_addr    v_do   exp_dout
    vecs[0] = '{1'b0, 16'h1234, 8'h00, 0, 1'b0, 16'h0000, 8'h00, 8'h5A};
    vecs[1] = '{1'b1, 16'h00FF, 8'hC3, 0, 1'b0, 16'h0000, 8'h00, 8'h5A};
    vecs[2] = '{1'b0, 16'h00FF, 8'h00, 0, 1'b0, 16'h0000, 8'h00, 8'hC3};
    vecs[3] = '{1'b0, 16'h1234, 8'h00, 5, 1'b0, 16'h4000, 8'h00, 8'h5A};
    vecs[4] = '{1'b1, 16'h2000, 8'h22, 3, 1'b1, 16'h2000, 8'h11, 8'h5A};
    vecs[5] = '{1'b0, 16'h2000, 8'h00, 0, 1'b0, 16'h0000, 8'h00, 8'h22};
    vecs[6] = '{1'b0, 16'hFFFF, 8'h00, 2, 1'b0, 16'h0001, 8'h00, 8'hEE};
    vecs[7] = '{1'b1, 16'h0000, 8'h01, 1, 1'b1, 16'h0000, 8'h77, 8'hEE};

    reset = 1'b1; vdp_active = 1'b0; vdp_addr = 16'h5555; vdp_we = 1'b0; vdp_do = 8'h00;
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_din = '0;
    repeat (2) @(negedge clk21m);
    reset = 1'b0;
    @(negedge clk21m);
    chk("rst_ack", 32'(host_ack), 32'd0);
    chk("rst_dout", 32'(host_dout), 32'd0);
    chk("rst_starve", 32'(host_starve), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ram_we", 32'(ram_we), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'h5555);

    foreach (vecs[i]) run_txn(vecs[i], 1'b0);
    chk("mem_2000", 32'(mem[16'h2000]), 32'h22);
    chk("mem_0000", 32'(mem[16'h0000]), 32'h01);

    // Back-to-back: req held through the ack cycle starts a second access
    @(negedge clk21m);
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;   // T0
    @(negedge clk21m);                                       // T1
    chk("b2b_t1_addr", 32'(ram_addr), 32'h1234);
    @(negedge clk21m);                                       // T2
    chk("b2b_ack1", 32'(host_ack), 32'd1);
    chk("b2b_dout1", 32'(host_dout), 32'h5A);
    host_addr = 16'h00FF;
    @(negedge clk21m);                                       // T3 idle, req seen
    chk("b2b_t3_busy", 32'(busy), 32'd0);
    chk("b2b_t3_ack", 32'(host_ack), 32'd0);
    @(negedge clk21m);                                       // T4 access
    host_req = 1'b0;
    #1;
    chk("b2b_t4_busy", 32'(busy), 32'd1);
    chk("b2b_t4_addr", 32'(ram_addr), 32'h00FF);
    @(negedge clk21m);                                       // T5 ack
    chk("b2b_ack2", 32'(host_ack), 32'd1);
    chk("b2b_dout2", 32'(host_dout), 32'hC3);
    @(negedge clk21m);
    chk("b2b_idle", 32'(busy), 32'd0);

    // Starvation: VDP holds the bank for 12 PEND cycles
    host_req = 1'b1; host_we = 1'b0; host_addr = 16'h1234;
    @(negedge clk21m);
    host_req = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      vdp_active = 1'b1; vdp_we = 1'b0;
      #1;
      chk("starve_pend", 32'(host_starve), 32'(STARVE_ON && (i > int'(LIMIT))));
      chk("starve_ram_we", 32'(ram_we), 32'd0);
      @(negedge clk21m);
    end
    vdp_active = 1'b0;
    @(negedge clk21m);
    chk("starve_ack", 32'(host_ack), 32'd1);
    chk("starve_dout", 32'(host_dout), 32'h5A);
    chk("starve_after_ack", 32'(host_starve), 32'(STARVE_ON));
    @(negedge clk21m);
    chk("starve_sticky", 32'(host_starve), 32'(STARVE_ON));

    // Reset during T1 of a pending write aborts it
    host_req = 1'b1; host_we = 1'b1; host_addr = 16'h3000; host_din = 8'h99;
    @(negedge clk21m);
    host_req = 1'b0; reset = 1'b1;
    #1;
    chk("rstmid_ram_we", 32'(ram_we), 32'd0);
    @(negedge clk21m);
    reset = 1'b0;
    chk("rstmid_busy", 32'(busy), 32'd0);
    chk("rstmid_ack", 32'(host_ack), 32'd0);
    chk("rstmid_dout", 32'(host_dout), 32'd0);
    chk("rstmid_starve", 32'(host_starve), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk21m);
      chk("rstmid_no_ack", 32'(host_ack), 32'd0);
      chk("rstmid_no_we", 32'(ram_we), 32'd0);
    end
    chk("rstmid_mem", 32'(mem[16'h3000]), 32'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
Name: vram_arbiter

Overview:
- Shares the single-port VRAM (one 64 KB bank, 1-cycle registered read) between two requesters.
- The active VDP has absolute priority and is never stalled.
- A secondary host port takes the cycles the VDP leaves idle. Host users are the savestate/debug DMA and the cartridge-load clear engine.
- Sits between the VDP VRAM address/data mux and the VRAM bank, in the clk21m domain.

Parameters:
- ADDR_W, 16, VRAM address width.
- STARVE_LIMIT, 1024, number of PEND cycles without a grant before the starvation flag is raised.

Ports:
- clk21m  in  1  system clock (21.477 MHz); all logic on its rising edge.
- reset  in  1  synchronous, active-high.
- vdp_active  in  1  VDP owns the VRAM this cycle.
- vdp_addr  in  ADDR_W  VDP address.
- vdp_we  in  1  VDP write enable.
- vdp_do  in  8  VDP write data.
- host_req  in  1  host request, level.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  ADDR_W  host address.
- host_din  in  8  host write data.
- host_ack  out  1  one-cycle completion pulse.
- host_dout  out  8  read data; valid while host_ack=1 and held afterwards.
- host_starve  out  1  sticky starvation flag.
- busy  out  1  host transaction in flight (state != IDLE).
- ram_addr  out  ADDR_W  to VRAM.
- ram_we  out  1  to VRAM.
- ram_data  out  8  to VRAM.
- ram_q  in  8  VRAM read data, registered, valid one cycle after the address.

Behaviour:
- Reset values: host_ack=0, host_dout=0, host_starve=0, busy=0, state=IDLE, starvation counter=0, latches=0.
- Reset is synchronous and active-high. Asserting it mid-transaction aborts the transaction: state returns to IDLE and no ack is issued.
- RAM mux is combinational:
  - vdp_active=1: ram_addr/ram_we/ram_data = vdp_addr/vdp_we/vdp_do.
  - Otherwise, in state PEND: the latched host addr, we and din.
  - Otherwise: ram_addr=vdp_addr, ram_we=0, ram_data=vdp_do.
- ram_we is never asserted for the host while vdp_active=1.
- State machine IDLE -> PEND -> DATA -> IDLE:
  - IDLE: if host_req=1, latch host_addr/host_we/host_din, clear the starvation counter, go to PEND.
  - PEND: if vdp_active=0, the host access is driven this cycle; go to DATA. Else stay in PEND and increment the starvation counter, saturating at STARVE_LIMIT.
  - DATA: host_dout <= ram_q for reads only (writes leave host_dout unchanged); host_ack=1 for this cycle; go to IDLE. Capture is unconditional; vdp_active in DATA does not affect the captured value.
- Latency: 3 cycles minimum from host_req sampled in IDLE to host_ack (T0 latch, T1 access, T2 ack). Each cycle vdp_active is high in PEND adds 1 cycle.
- Handshake rules:
  - host_req is sampled only in IDLE.
  - Dropping host_req during PEND or DATA does not cancel the transaction.
  - Host inputs other than host_req are ignored outside IDLE.
  - If host_req is still 1 in the cycle after host_ack, a new transaction starts. Hosts wanting a single access must drop req in the ack cycle.
- Address arithmetic: none. No wrap, addresses pass through unchanged.
- host_starve is set when the counter reaches STARVE_LIMIT while in PEND. It is cleared only by reset.
- busy = (state != IDLE).

Optional Feature:
- Macro: VRAM_ARB_STARVE_EN.
- Defined: starvation counter (width clog2(STARVE_LIMIT+1)) and host_starve behave as above.
- Undefined: counter not instantiated; host_starve tied to 0. All other timing is identical.

Test Plan:
- Host read, VDP idle: VRAM[0x1234]=0x5A, host_req at T0 with host_we=0, addr=0x1234 -> ram_addr=0x1234 at T1; host_ack=1 and host_dout=0x5A at T2; busy high T1-T2.
- Host write then read: write 0xC3 to 0x00FF -> ram_we=1 only at T1, ack at T2. A following read of 0x00FF returns 0xC3.
- VDP contention: vdp_active high for 5 cycles from T1 -> ram follows VDP, host ram_we never seen. Access occurs at T6, ack at T7, data correct.
- Simultaneous VDP write and pending host write, both to 0x2000: VDP writes 0x11 while active, host writes 0x22 after. Final VRAM[0x2000]=0x22 and no write collision cycle.
- Reset at T1 of a pending write -> no ack, no ram_we, state IDLE, host_dout=0.
- With VRAM_ARB_STARVE_EN, STARVE_LIMIT=8, vdp_active held high -> host_starve rises after 8 PEND cycles and stays 1 after the grant. Without the macro it stays 0.
